// File: rtl/updown_pkg.sv
// Shared encodings for the up/down counter family: direction polarity,
// step classes and decoder FSM states.
package updown_pkg;

  // Matches the counter's m input: 0 counts up, 1 counts down.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2,
    STEP_JUMP = 2'd3
  } step_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  function automatic logic step_dir(input step_e s);
    return (s == STEP_DOWN) ? DIR_DOWN : DIR_UP;
  endfunction

endpackage

// File: rtl/updown_dir_decoder_if.sv
// Observation bus between a sample source and the direction decoder.
interface updown_dir_decoder_if #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 8
) ();
  // valid_in qualifies q_in for one cycle; there is no ready, the decoder
  // accepts every valid sample on the edge it is presented.
  logic             valid_in;
  logic [WIDTH-1:0] q_in;
  logic             err_clr;
  logic             m_out;
  logic             dir_valid;
  logic             hold_out;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output valid_in, q_in, err_clr,
    input  m_out, dir_valid, hold_out, err_pulse, err_cnt
  );

  modport slave (
    input  valid_in, q_in, err_clr,
    output m_out, dir_valid, hold_out, err_pulse, err_cnt
  );
endinterface

// File: rtl/updown_step_classify.sv
// Classifies one counter step from the modular difference of two samples.
module updown_step_classify
  import updown_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] prev_q,
  input  logic [WIDTH-1:0] q_in,
  output step_e            step
);

  logic [WIDTH-1:0] delta;

  // Truncation to WIDTH bits makes max->0 an UP step and 0->max a DOWN step.
  assign delta = q_in - prev_q;

  always_comb begin
    step = STEP_JUMP;
    if (delta == '0)
      step = STEP_HOLD;
    else if (delta == WIDTH'(1))
      step = STEP_UP;
    else if (delta == '1)
      step = STEP_DOWN;
  end

endmodule

// File: rtl/updown_dir_decoder.sv
// Recovers the mode bit of an observed up/down counter and counts illegal
// jumps in its output stream.
module updown_dir_decoder
  import updown_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_dir_decoder_if.slave  bus,
  output state_e               state_dbg,
  output logic [3:0]           run_dbg
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic             cand_q, cand_d;
  logic             m_q, m_d;
  logic             dv_q, dv_d;
  logic             hold_q, hold_d;
  logic             errp_q, errp_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  step_e step;
  logic  dir;
  logic  jump;

  updown_step_classify #(.WIDTH(WIDTH)) u_classify (
    .prev_q (prev_q),
    .q_in   (bus.q_in),
    .step   (step)
  );

  assign dir  = step_dir(step);
  assign jump = bus.valid_in && (state_q != S_IDLE) && (step == STEP_JUMP);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    cand_d  = cand_q;
    m_d     = m_q;
    dv_d    = dv_q;
    hold_d  = 1'b0;
    errp_d  = 1'b0;
    if (bus.valid_in) begin
      prev_d = bus.q_in;
      case (state_q)
        S_IDLE: begin
          state_d = S_ACQ;
          run_d   = '0;
        end
        S_ACQ: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              if (run_q == '0 || dir != cand_q) begin
                cand_d = dir;
                run_d  = 4'd1;
              end else begin
                run_d  = run_q + 4'd1;
              end
              if (run_d >= LOCK_V) begin
                state_d = S_LOCKED;
                dv_d    = 1'b1;
                m_d     = cand_d;
              end
            end
            STEP_HOLD: hold_d = 1'b1;
            default: begin
              errp_d = 1'b1;
              run_d  = '0;
            end
          endcase
        end
        S_LOCKED: begin
          case (step)
            STEP_UP, STEP_DOWN: begin
              if (dir != cand_q) begin
                cand_d = dir;
                run_d  = 4'd1;
                // A single-step lock threshold relocks on the reversal itself.
                if (LOCK_V == 4'd1) begin
                  m_d = dir;
                end else begin
                  state_d = S_ACQ;
                  dv_d    = 1'b0;
                end
              end
            end
            STEP_HOLD: hold_d = 1'b1;
            default: begin
              errp_d  = 1'b1;
              run_d   = '0;
              state_d = S_ACQ;
              dv_d    = 1'b0;
            end
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A clear that coincides with a jump still records that jump.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.err_clr)
      cnt_d = jump ? ERR_W'(1) : '0;
    else if (jump && cnt_q != '1)
      cnt_d = cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      run_q   <= '0;
      cand_q  <= 1'b0;
      m_q     <= 1'b0;
      dv_q    <= 1'b0;
      hold_q  <= 1'b0;
      errp_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      cand_q  <= cand_d;
      m_q     <= m_d;
      dv_q    <= dv_d;
      hold_q  <= hold_d;
      errp_q  <= errp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_out     = m_q;
  assign bus.dir_valid = dv_q;
  assign bus.hold_out  = hold_q;
  assign bus.err_pulse = errp_q;
  assign bus.err_cnt   = cnt_q;
  assign state_dbg     = state_q;
  assign run_dbg       = run_q;

endmodule
